// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment digit scanner with a per-frame BCD snapshot.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module display_scan_mux #(
   parameter int N_DIGITS    = 4,
   parameter int REFRESH_DIV = 10000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [4*N_DIGITS-1:0]   cdu,
   output logic [N_DIGITS-1:0]     a,
   output logic [3:0]              w,
   output logic                    blank
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

   logic [CW-1:0]         cnt_r;
   logic [IW-1:0]         idx_r;
   logic [4*N_DIGITS-1:0] frame_r;
   logic [3:0]            digit_s;
   logic                  blank_s;

   // Refresh counter, digit index and frame snapshot; cdu is only taken at a frame wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r   <= {CW{1'b0}};
         idx_r   <= {IW{1'b0}};
         frame_r <= {(4*N_DIGITS){1'b0}};
      end else if (en) begin
         if (cnt_r == CNT_LAST) begin
            cnt_r <= {CW{1'b0}};
            if (idx_r == IDX_LAST) begin
               idx_r   <= {IW{1'b0}};
               frame_r <= cdu;
            end else begin
               idx_r   <= idx_r + {{(IW-1){1'b0}}, 1'b1};
            end
         end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
         end
      end
   end

   assign digit_s = frame_r[{idx_r, 2'b00} +: 4];

`ifdef DISP_LZB_EN
   logic [N_DIGITS-1:0] zero_up_s;

   // zero_up_s[i] is set when frame digit i and every digit above it are zero
   always_comb begin
      logic acc_s;
      acc_s     = 1'b1;
      zero_up_s = {N_DIGITS{1'b0}};
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         acc_s        = acc_s & (frame_r[4*i +: 4] == 4'h0);
         zero_up_s[i] = acc_s;
      end
   end

   assign blank_s = (idx_r != {IW{1'b0}}) && zero_up_s[idx_r];
`else
   assign blank_s = 1'b0;
`endif

   // Display drive: everything off while disabled, blanked digits force w to zero
   always_comb begin
      a     = {N_DIGITS{1'b0}};
      w     = 4'h0;
      blank = 1'b0;
      if (en) begin
         a = N_DIGITS'(1'b1) << idx_r;
         if (blank_s) begin
            blank = 1'b1;
            w     = 4'h0;
         end else begin
            blank = 1'b0;
            w     = digit_s;
         end
      end else begin
         a     = {N_DIGITS{1'b0}};
         w     = 4'h0;
         blank = 1'b0;
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux (N_DIGITS=4, REFRESH_DIV=4).
module tb_display_scan_mux;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] w;
      logic       blank;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b1;
   logic [15:0] cdu = 16'h0000;
   logic [3:0]  a;
   logic [3:0]  w;
   logic        blank;

   sb_t sb[$];
   sb_t e;
   int  errors = 0;
   int  checks = 0;

   display_scan_mux #(.N_DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .en(en), .cdu(cdu), .a(a), .w(w), .blank(blank)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Expected display for frame f showing digit i with enable en_v
   function automatic sb_t exp_at(input logic [15:0] f, input int i, input logic en_v);
      sb_t r;
      r.a     = en_v ? (4'b0001 << i) : 4'b0000;
      r.w     = 4'h0;
      r.blank = 1'b0;
      if (en_v) begin
`ifdef DISP_LZB_EN
         if (i > 0 && (f >> (4*i)) == 16'h0000) r.blank = 1'b1;
         else r.w = f[4*i +: 4];
`else
         r.w = f[4*i +: 4];
`endif
      end
      return r;
   endfunction

   // k counts enabled edges since reset; frame is f0 before the first wrap, f1 after
   task automatic push_frames(input int k0, input int k1, input logic [15:0] f0, input logic [15:0] f1);
      for (int k = k0; k < k1; k++)
         sb.push_back(exp_at((k < 16) ? f0 : f1, (k / 4) % 4, 1'b1));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; cdu = 16'h9999;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (a !== 4'b0001) begin errors++; $display("FAIL reset_a: got %b want 0001", a); end
      checks++;
      if (w !== 4'h0) begin errors++; $display("FAIL reset_w: got %h want 0", w); end
      checks++;
      if (blank !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b want 0", blank); end
      rst = 1'b0;
      push_frames(0, 20, 16'h0000, 16'h9999);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         #1;
         checks++;
         if ({a, w, blank} !== e) begin
            errors++;
            $display("FAIL reset_scan: got a=%b w=%h blank=%b want a=%b w=%h blank=%b", a, w, blank, e.a, e.w, e.blank);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_scan_order();
      en = 1'b1; cdu = 16'h1234;
      apply_reset();
      push_frames(0, 36, 16'h0000, 16'h1234);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         #1;
         checks++;
         if ({a, w, blank} !== e) begin
            errors++;
            $display("FAIL scan_order: got a=%b w=%h blank=%b want a=%b w=%h blank=%b", a, w, blank, e.a, e.w, e.blank);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_snapshot();
      en = 1'b1; cdu = 16'h1234;
      apply_reset();
      repeat (24) @(negedge clk);
      // now showing digit 2 of frame 1234; new cdu must wait for the next wrap
      cdu = 16'h5678;
      for (int k = 24; k < 32; k++) sb.push_back(exp_at(16'h1234, (k / 4) % 4, 1'b1));
      for (int k = 32; k < 48; k++) sb.push_back(exp_at(16'h5678, (k / 4) % 4, 1'b1));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         #1;
         checks++;
         if ({a, w, blank} !== e) begin
            errors++;
            $display("FAIL snapshot: got a=%b w=%h blank=%b want a=%b w=%h blank=%b", a, w, blank, e.a, e.w, e.blank);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_enable();
      en = 1'b1; cdu = 16'h1234;
      apply_reset();
      repeat (22) @(negedge clk);
      en = 1'b0;
      for (int k = 0; k < 10; k++) sb.push_back(exp_at(16'h1234, 1, 1'b0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         #1;
         checks++;
         if ({a, w, blank} !== e) begin
            errors++;
            $display("FAIL enable_gap: got a=%b w=%h blank=%b want a=%b w=%h blank=%b", a, w, blank, e.a, e.w, e.blank);
         end
         @(negedge clk);
      end
      en = 1'b1;
      push_frames(22, 36, 16'h1234, 16'h1234);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         #1;
         checks++;
         if ({a, w, blank} !== e) begin
            errors++;
            $display("FAIL enable_resume: got a=%b w=%h blank=%b want a=%b w=%h blank=%b", a, w, blank, e.a, e.w, e.blank);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_blanking();
      en = 1'b1; cdu = 16'h0070;
      apply_reset();
      repeat (16) @(negedge clk);
      cdu = 16'h0000;
      for (int k = 16; k < 32; k++) sb.push_back(exp_at(16'h0070, (k / 4) % 4, 1'b1));
      for (int k = 32; k < 48; k++) sb.push_back(exp_at(16'h0000, (k / 4) % 4, 1'b1));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         #1;
         checks++;
         if ({a, w, blank} !== e) begin
            errors++;
            $display("FAIL blanking: got a=%b w=%h blank=%b want a=%b w=%h blank=%b", a, w, blank, e.a, e.w, e.blank);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mid_reset();
      en = 1'b1; cdu = 16'h1234;
      apply_reset();
      repeat (28) @(negedge clk);
      sb.push_back(exp_at(16'h1234, 3, 1'b1));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         #1;
         checks++;
         if ({a, w, blank} !== e) begin
            errors++;
            $display("FAIL mid_reset_pre: got a=%b w=%h blank=%b want a=%b w=%h blank=%b", a, w, blank, e.a, e.w, e.blank);
         end
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cdu = 16'h5678;
      push_frames(0, 20, 16'h0000, 16'h5678);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         #1;
         checks++;
         if ({a, w, blank} !== e) begin
            errors++;
            $display("FAIL mid_reset_post: got a=%b w=%h blank=%b want a=%b w=%h blank=%b", a, w, blank, e.a, e.w, e.blank);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_snapshot();
      test_enable();
      test_blanking();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
